// File: rtl/addsub_pkg.sv
// Shared definitions for the segmented add/subtract pipeline.
// Holds the op encodings and two small helpers that turn an op into the
// effective B inversion and effective carry-in of the first segment.
package addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBC = 2'b11
    } addsub_op_e;

    // SUB and SBC add the one's complement of B.
    function automatic logic op_inverts_b(input addsub_op_e op);
        return (op == OP_SUB) || (op == OP_SBC);
    endfunction

    // ADD forces 0, SUB forces 1 (completing the two's complement),
    // ADC/SBC pass the external carry-in through.
    function automatic logic op_carry_in(input addsub_op_e op, input logic cin);
        logic c;
        case (op)
            OP_ADD:  c = 1'b0;
            OP_SUB:  c = 1'b1;
            default: c = cin;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cla_seg.sv
// Combinational SEG-bit carry-lookahead adder segment.
// Ports:
//   RA, RB  : segment operands (RB already inverted by the caller if needed)
//   cin     : carry into bit 0
//   sum     : segment sum
//   cout    : carry out of the segment MSB
//   c_msb   : carry into the segment MSB (used for signed overflow at the top)
module cla_seg #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] RA,
    input  logic [SEG-1:0] RB,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           c_msb
);

    logic [SEG-1:0] w_g;
    logic [SEG-1:0] w_p;
    logic [SEG:0]   w_c;

    assign w_g = RA & RB;
    assign w_p = RA ^ RB;

    // Every carry is formed from the group generate/propagate of the bits
    // below it and cin directly, so no carry depends on another carry.
    always_comb begin
        logic v_gg;
        logic v_pp;
        v_gg   = 1'b0;
        v_pp   = 1'b1;
        w_c    = '0;
        w_c[0] = cin;
        for (int i = 0; i < SEG; i++) begin
            v_gg = 1'b0;
            v_pp = 1'b1;
            for (int j = 0; j <= i; j++) begin
                v_gg = w_g[j] | (w_p[j] & v_gg);
                v_pp = v_pp & w_p[j];
            end
            w_c[i+1] = v_gg | (v_pp & cin);
        end
    end

    assign sum   = w_p ^ w_c[SEG-1:0];
    assign cout  = w_c[SEG];
    assign c_msb = w_c[SEG-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Segmented, pipelined add/subtract unit (ADD, SUB, ADC, SBC).
// One SEG-bit carry-lookahead segment per stage; carries ripple between
// stages through registers, unconsumed operand bits are skewed forward and
// finished result bits trail along so each beat leaves as a whole word.
// Latency is WIDTH/SEG cycles, throughput one beat per cycle, and a single
// global stall freezes the whole pipe while the output is not accepted.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_valid / in_ready : input handshake (in_ready = not stalled)
//   op, RA, RB, cin     : operation, operands, carry-in (ADC/SBC only)
//   out_valid/out_ready : output handshake
//   sum, cout, overflow, zero : registered result and flags
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG   = 8     // WIDTH must be a multiple of SEG
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] RA,
    input  logic [WIDTH-1:0] RB,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int STAGES = WIDTH / SEG;

    logic              w_stall;
    logic [WIDTH-1:0]  w_b_eff;
    logic              w_cin_eff;
    logic [STAGES-1:0] r_vld;
    logic [STAGES-1:0] w_vld_next;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;
    logic              r_ovf;
    logic              r_zero;

    assign w_b_eff   = op_inverts_b(addsub_op_e'(op)) ? ~RB : RB;
    assign w_cin_eff = op_carry_in(addsub_op_e'(op), cin);

    assign w_stall   = r_vld[STAGES-1] && !out_ready;
    assign in_ready  = !w_stall;

    // Valid bits shift with the data; an idle input injects a bubble.
    always_comb begin
        w_vld_next    = r_vld;
        w_vld_next[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            w_vld_next[k] = r_vld[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= '0;
        end else if (!w_stall) begin
            r_vld <= w_vld_next;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int LO = k * SEG;   // result bits already finished

        logic [SEG-1:0]    w_a_seg;
        logic [SEG-1:0]    w_b_seg;
        logic [SEG-1:0]    w_sum_seg;
        logic              w_cin;
        logic              w_cout;
        logic              w_c_msb;
        logic [LO+SEG-1:0] w_res;

        // ---- stage k input: raw ports for k=0, previous stage registers otherwise
        if (k == 0) begin : g_src
            assign w_a_seg = RA[SEG-1:0];
            assign w_b_seg = w_b_eff[SEG-1:0];
            assign w_cin   = w_cin_eff;
            assign w_res   = w_sum_seg;
        end else begin : g_src
            assign w_a_seg = g_st[k-1].g_mid.r_a_up[SEG-1:0];
            assign w_b_seg = g_st[k-1].g_mid.r_b_up[SEG-1:0];
            assign w_cin   = g_st[k-1].g_mid.r_c;
            assign w_res   = {w_sum_seg, g_st[k-1].g_mid.r_res};
        end

        cla_seg #(.SEG(SEG)) u_cla (
            .RA    (w_a_seg),
            .RB    (w_b_seg),
            .cin   (w_cin),
            .sum   (w_sum_seg),
            .cout  (w_cout),
            .c_msb (w_c_msb)
        );

        if (k < STAGES-1) begin : g_mid
            localparam int AW = WIDTH - (k + 1) * SEG;   // operand bits still to add

            logic [AW-1:0]     w_a_up;
            logic [AW-1:0]     w_b_up;
            logic [AW-1:0]     r_a_up;
            logic [AW-1:0]     r_b_up;
            logic [LO+SEG-1:0] r_res;
            logic              r_c;
            logic              w_c_msb_unused;

            // The MSB carry-in only matters for the top segment.
            assign w_c_msb_unused = w_c_msb;

            if (k == 0) begin : g_up
                assign w_a_up = RA[WIDTH-1:SEG];
                assign w_b_up = w_b_eff[WIDTH-1:SEG];
            end else begin : g_up
                assign w_a_up = g_st[k-1].g_mid.r_a_up[AW+SEG-1:SEG];
                assign w_b_up = g_st[k-1].g_mid.r_b_up[AW+SEG-1:SEG];
            end

            // ---- stage k register boundary
            always_ff @(posedge clk) begin
                if (!w_stall) begin
                    r_a_up <= w_a_up;
                    r_b_up <= w_b_up;
                    r_res  <= w_res;
                    r_c    <= w_cout;
                end
            end
        end else begin : g_last
            // ---- output register boundary
            // cout ^ (carry into MSB) is the same signed-overflow condition as
            // "operands share a sign that the sum does not".
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sum  <= '0;
                    r_cout <= 1'b0;
                    r_ovf  <= 1'b0;
                    r_zero <= 1'b0;
                end else if (!w_stall) begin
                    r_sum  <= w_res;
                    r_cout <= w_cout;
                    r_ovf  <= w_cout ^ w_c_msb;
                    r_zero <= (w_res == '0);
                end
            end
        end
    end

    assign out_valid = r_vld[STAGES-1];
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign overflow  = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub (WIDTH=32, SEG=8, latency 4).
// A negedge monitor keeps a queue of expected results computed with plain
// 33-bit arithmetic and checks order, latency, stall behaviour and flags.
module tb_pipelined_addsub;
    import addsub_pkg::*;

    localparam int WIDTH  = 32;
    localparam int SEG    = 8;
    localparam int STAGES = WIDTH / SEG;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] RA;
    logic [WIDTH-1:0] RB;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             zero;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          acc;
        int          st;
    } exp_t;

    exp_t q[$];
    int   n_chk     = 0;
    int   n_err     = 0;
    int   cyc       = 0;
    int   stall_cnt = 0;
    int   n_acc     = 0;
    int   n_del     = 0;
    int   n_flush   = 0;
    logic prev_rst  = 1'b0;

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .RA        (RA),
        .RB        (RB),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a,
                                   input logic [31:0] b, input logic c);
        exp_t        e;
        logic [32:0] full;
        logic [31:0] bb;
        logic        ci;
        bb     = (o == OP_SUB || o == OP_SBC) ? ~b : b;
        ci     = (o == OP_ADD) ? 1'b0 : (o == OP_SUB) ? 1'b1 : c;
        full   = {1'b0, a} + {1'b0, bb} + {32'b0, ci};
        e.sum  = full[31:0];
        e.cout = full[32];
        e.ovf  = (a[31] == bb[31]) && (full[31] != a[31]);
        e.zero = (full[31:0] == 32'd0);
        e.acc  = cyc;
        e.st   = stall_cnt;
        return e;
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] edges [4];
        edges[0] = 32'h0000_0000;
        edges[1] = 32'hFFFF_FFFF;
        edges[2] = 32'h8000_0000;
        edges[3] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 3)];
        return $urandom;
    endfunction

    // Monitor: everything here is sampled mid-cycle, when inputs and
    // registered outputs are settled for the coming rising edge.
    initial begin
        int age;
        forever begin
            @(negedge clk);
            if (prev_rst) begin
                check("rst_out_valid", 64'(out_valid), 64'(0));
                check("rst_sum",       64'(sum),       64'(0));
                check("rst_cout",      64'(cout),      64'(0));
                check("rst_ovf",       64'(overflow),  64'(0));
                check("rst_zero",      64'(zero),      64'(0));
            end
            if (reset) begin
                n_flush += q.size();
                q.delete();
            end else begin
                if (out_valid) begin
                    if (q.size() == 0) begin
                        check("spurious_out_valid", 64'(out_valid), 64'(0));
                    end else begin
                        age = cyc - q[0].acc - (stall_cnt - q[0].st);
                        check("latency",  64'(age),      64'(STAGES));
                        check("sum",      64'(sum),      64'(q[0].sum));
                        check("cout",     64'(cout),     64'(q[0].cout));
                        check("overflow", 64'(overflow), 64'(q[0].ovf));
                        check("zero",     64'(zero),     64'(q[0].zero));
                        if (out_ready) begin
                            void'(q.pop_front());
                            n_del++;
                        end
                    end
                end else if (q.size() > 0) begin
                    age = cyc - q[0].acc - (stall_cnt - q[0].st);
                    check("result_late", 64'(age < STAGES), 64'(1));
                end
                check("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
                if (in_valid && in_ready) begin
                    q.push_back(model(op, RA, RB, cin));
                    n_acc++;
                end
                if (out_valid && !out_ready) stall_cnt++;
            end
            prev_rst = reset;
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic c);
        op       = o;
        RA       = a;
        RB       = b;
        cin      = c;
        in_valid = 1'b1;
    endtask

    task automatic drive_random();
        drive(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
    endtask

    // Single isolated beat with explicitly known results.
    task automatic directed(input string tag, input logic [1:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic c, input logic [31:0] e_sum,
                            input logic e_cout, input logic e_ovf, input logic e_zero);
        int lat;
        lat = -1;
        out_ready = 1'b1;
        drive(o, a, b, c);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i + 1;
                break;
            end
        end
        check({tag, "_lat"}, 64'(lat), 64'(STAGES));
        check({tag, "_sum"}, 64'(sum), 64'(e_sum));
        check({tag, "_cout"}, 64'(cout), 64'(e_cout));
        check({tag, "_ovf"}, 64'(overflow), 64'(e_ovf));
        check({tag, "_zero"}, 64'(zero), 64'(e_zero));
        @(posedge clk);
        #1;
    endtask

    // Back-to-back random beats; the source holds a beat until accepted.
    task automatic stream(input int n, input int st_at, input int st_len, input bit rnd_rdy);
        int   sent;
        int   k;
        logic acc;
        sent = 0;
        k    = 0;
        drive_random();
        while (sent < n && k < 2000) begin
            out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : !(k >= st_at && k < st_at + st_len);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                sent++;
                if (sent < n) drive_random();
                else in_valid = 1'b0;
            end
            k++;
        end
        check("stream_sent", 64'(sent), 64'(n));
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain_empty", 64'(q.size()), 64'(0));
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b1;    // must be ignored while reset is high
        op        = OP_ADD;
        RA        = 32'h1234_5678;
        RB        = 32'h0000_0001;
        cin       = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'(in_ready), 64'(1));
        check("idle_after_rst",  64'(out_valid), 64'(0));
        @(posedge clk);
        #1;

        directed("add_wrap",  OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        directed("sub_ovf",   OP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        directed("sub_brw",   OP_SUB, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        directed("adc_ovf",   OP_ADC, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        directed("sbc_c0",    OP_SBC, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
        directed("sub_eq",    OP_SUB, 32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        directed("add_cin_x", OP_ADD, 32'h0000_00FF, 32'h0000_0001, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0);

        stream(16, 1000, 0, 1'b0);
        drain();
        stream(10, 6, 3, 1'b0);
        drain();
        stream(40, 0, 0, 1'b1);
        drain();

        // Three beats in flight, then a one-cycle reset pulse.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_random();
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        repeat (8) @(posedge clk);
        #1;
        directed("post_rst", OP_ADD, 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
        drain();

        check("midrst_flushed", 64'(n_flush), 64'(3));
        check("exactly_once",   64'(n_del),   64'(n_acc - n_flush));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
